// File: rtl/float8_accum.sv
// Float8 product accumulator: sums decoded products in fixed point, then renormalises to Float8.
// Optional ReLU on the result is enabled by defining FLOAT8_ACCUM_RELU_EN.
module float8_accum #(
  parameter int ACC_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iValid,
  input  logic [7:0] iNum,
  input  logic       iOverflow,
  input  logic       iLast,
  output logic       oReady,
  output logic       oValid,
  output logic [7:0] oNum,
  output logic       overflow
);

  typedef enum logic [1:0] {ACC, NORM, OUT} stateT;

  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = -ACC_MAX;

  stateT                    state;
  logic signed [ACC_W-1:0]  acc;
  logic                     sticky;
  logic                     accept;

  logic        [ACC_W-1:0]  decMag;
  logic signed [ACC_W-1:0]  decVal;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  sumSat;
  logic                     sumOvf;

  logic                     accNeg;
  logic        [ACC_W-1:0]  accMag;
  logic        [7:0]        normNum;
  logic                     normOvf;
  logic                     unusedLsb;

  assign oReady = (state == ACC);
  assign accept = iValid && oReady;

  // Decode the incoming product and add it with symmetric saturation.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    decMag = '0;
    decVal = '0;
    if (iNum[6:4] != 3'd0) begin
      decMag = ACC_W'({1'b1, iNum[3:0]}) << iNum[6:4];
      decVal = iNum[7] ? -$signed(decMag) : $signed(decMag);
    end
    sum    = $signed({acc[ACC_W-1], acc}) + $signed({decVal[ACC_W-1], decVal});
    sumOvf = 1'b0;
    sumSat = sum[ACC_W-1:0];
    if (sum > ACC_MAX) begin
      sumSat = ACC_MAX[ACC_W-1:0];
      sumOvf = 1'b1;
    end else if (sum < ACC_MIN) begin
      sumSat = ACC_MIN[ACC_W-1:0];
      sumOvf = 1'b1;
    end
  end

  // Leading-one search over bits 11..5; the highest set bit wins because it is assigned last.
  always_comb begin
    accNeg  = acc[ACC_W-1];
    accMag  = accNeg ? -acc : acc;
    normNum = 8'h00;
    normOvf = sticky;
    if (|accMag[ACC_W-1:12]) begin
      normNum = {accNeg, 7'h7F};
      normOvf = 1'b1;
    end else begin
      for (int p = 5; p <= 11; p++) begin
        if (accMag[p]) normNum = {accNeg, 3'(p - 4), accMag[p-1 -: 4]};
      end
    end
`ifdef FLOAT8_ACCUM_RELU_EN
    if (accNeg) begin
      normNum = 8'h00;
      normOvf = sticky;
    end
`endif
  end

  // Bit 0 sits below the smallest representable result and is always truncated away.
  assign unusedLsb = accMag[0];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      sticky   <= 1'b0;
      oValid   <= 1'b0;
      oNum     <= 8'h00;
      overflow <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc    <= sumSat;
            sticky <= sticky | iOverflow | sumOvf;
            if (iLast) state <= NORM;
          end
        end
        NORM: begin
          oNum     <= normNum;
          overflow <= normOvf;
          oValid   <= 1'b1;
          state    <= OUT;
        end
        OUT: begin
          oValid <= 1'b0;
          acc    <= '0;
          sticky <= 1'b0;
          state  <= ACC;
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_float8_accum.sv
// Directed bench for float8_accum: vector table of short sums plus reset and saturation sequences.
// Expected values follow FLOAT8_ACCUM_RELU_EN when it is defined for the build.
module tb_float8_accum;

`ifdef FLOAT8_ACCUM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       iValid;
  logic [7:0] iNum;
  logic       iOverflow;
  logic       iLast;
  logic       oReady;
  logic       oValid;
  logic [7:0] oNum;
  logic       overflow;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       o0;
    logic       o1;
    logic       hold;
    logic [7:0] expNum;
    logic       expOvf;
  } vecT;

  vecT vecs[16];

  float8_accum #(.ACC_W(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .iValid   (iValid),
    .iNum     (iNum),
    .iOverflow(iOverflow),
    .iLast    (iLast),
    .oReady   (oReady),
    .oValid   (oValid),
    .oNum     (oNum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts and ends just after a falling edge; the beat is taken on the next rising edge with oReady high.
  task automatic sendBeat(input logic [7:0] num, input logic ovf, input logic last);
    int waitCnt;
    iValid    = 1'b1;
    iNum      = num;
    iOverflow = ovf;
    iLast     = last;
    waitCnt   = 0;
    while (!oReady && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    check("oReady before beat", {7'b0, oReady}, 8'h01);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in the cycle after the last beat was taken; checks the t+2 pulse and t+3 ready.
  task automatic finishSum(input string name, input logic [7:0] expNum, input logic expOvf,
                           input logic hold);
    if (hold) begin
      iValid = 1'b1; iNum = 8'h7F; iOverflow = 1'b1; iLast = 1'b1;
    end else begin
      iValid = 1'b0;
    end
    check({name, " oValid@t+1"}, {7'b0, oValid}, 8'h00);
    check({name, " oReady@t+1"}, {7'b0, oReady}, 8'h00);
    @(negedge clk);
    check({name, " oValid@t+2"}, {7'b0, oValid}, 8'h01);
    check({name, " oReady@t+2"}, {7'b0, oReady}, 8'h00);
    check({name, " oNum"}, oNum, expNum);
    check({name, " overflow"}, {7'b0, overflow}, {7'b0, expOvf});
    @(negedge clk);
    iValid = 1'b0;
    check({name, " oValid@t+3"}, {7'b0, oValid}, 8'h00);
    check({name, " oReady@t+3"}, {7'b0, oReady}, 8'h01);
    check({name, " oNum held"}, oNum, expNum);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 8'h50, 1'b0};
    vecs[1]  = '{2, 8'h40, 8'hC0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{2, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b1};
    vecs[3]  = '{1, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0};
    vecs[4]  = '{1, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b0, RELU ? 8'h00 : 8'hA0, 1'b0};
    vecs[5]  = '{2, 8'h40, 8'h00, 1'b1, 1'b0, 1'b1, 8'h40, 1'b1};
    vecs[6]  = '{2, 8'h48, 8'h48, 1'b0, 1'b0, 1'b0, 8'h58, 1'b0};
    vecs[7]  = '{2, 8'h11, 8'h10, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0};
    vecs[8]  = '{2, 8'h11, 8'h90, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{2, 8'h0F, 8'h40, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0};
    vecs[10] = '{2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, RELU ? 8'h00 : 8'hFF, !RELU};
    vecs[11] = '{1, 8'hC8, 8'h00, 1'b0, 1'b0, 1'b0, RELU ? 8'h00 : 8'hC8, 1'b0};
    vecs[12] = '{1, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0};
    vecs[13] = '{1, 8'h70, 8'h00, 1'b0, 1'b0, 1'b0, 8'h70, 1'b0};
    vecs[14] = '{1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[15] = '{2, 8'h10, 8'h91, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    rst = 1'b1; iValid = 1'b0; iNum = 8'h00; iOverflow = 1'b0; iLast = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset oReady", {7'b0, oReady}, 8'h01);
    check("reset oValid", {7'b0, oValid}, 8'h00);
    check("reset oNum", oNum, 8'h00);
    check("reset overflow", {7'b0, overflow}, 8'h00);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].n == 2) begin
        sendBeat(vecs[i].b0, vecs[i].o0, 1'b0);
        sendBeat(vecs[i].b1, vecs[i].o1, 1'b1);
      end else begin
        sendBeat(vecs[i].b0, vecs[i].o0, 1'b1);
      end
      finishSum($sformatf("vec%0d", i), vecs[i].expNum, vecs[i].expOvf, vecs[i].hold);
    end

    // Accumulator saturation: 141 beats of -3968 exceed -(2^19-1).
    for (int i = 0; i < 140; i++) sendBeat(8'hFF, 1'b0, 1'b0);
    sendBeat(8'hFF, 1'b0, 1'b1);
    finishSum("accsat", RELU ? 8'h00 : 8'hFF, 1'b1, 1'b0);

    // Reset while in NORM: no pulse, outputs return to reset values.
    sendBeat(8'h40, 1'b0, 1'b1);
    iValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("normrst oValid", {7'b0, oValid}, 8'h00);
    check("normrst oReady", {7'b0, oReady}, 8'h01);
    check("normrst oNum", oNum, 8'h00);
    check("normrst overflow", {7'b0, overflow}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("normrst no pulse", {7'b0, oValid}, 8'h00);
    end

    // Reset mid-sum discards the partial sum.
    sendBeat(8'h40, 1'b0, 1'b0);
    iValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst oValid", {7'b0, oValid}, 8'h00);
    sendBeat(8'h20, 1'b0, 1'b1);
    finishSum("midrst", 8'h20, 1'b0, 1'b0);

    // Reset wins over a beat presented in the same cycle.
    rst = 1'b1; iValid = 1'b1; iNum = 8'h40; iOverflow = 1'b1; iLast = 1'b0;
    @(negedge clk);
    rst = 1'b0; iValid = 1'b0;
    sendBeat(8'h20, 1'b0, 1'b1);
    finishSum("rstprio", 8'h20, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/float8_accum.md
FLOAT8_ACCUM -- requirements
Module: float8_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 20, giving the signed accumulator width; the LSB weight is 2^-8.
REQ-002 SHALL have input clk, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 SHALL have input rst, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have input iValid, 1 bit: iNum/iOverflow/iLast carry a product this cycle.
REQ-005 SHALL have input iNum, 8 bits: Float8 product from the multiplier stage; bit7 sign, [6:4] exponent (bias 4), [3:0] mantissa with hidden 1.
REQ-006 SHALL have input iOverflow, 1 bit: the multiplier's overflow flag for this product.
REQ-007 SHALL have input iLast, 1 bit: this product is the final term of the current sum.
REQ-008 SHALL have output oReady, 1 bit: the block accepts a product this cycle.
REQ-009 SHALL have output oValid, 1 bit: single-cycle pulse marking a result.
REQ-010 SHALL have output oNum, 8 bits: the Float8 result, in the same format as iNum.
REQ-011 SHALL have output overflow, 1 bit: the result saturated or a contributing product overflowed; valid while oValid is high.

Function
REQ-012 SHALL use an FSM with states ACC, NORM and OUT.
REQ-013 SHALL assert oReady only in ACC; a beat is accepted when iValid && oReady.
REQ-014 SHALL ignore iValid, iNum and iLast while in NORM or OUT (no accept, no buffering).
REQ-015 SHALL decode an accepted product to fixed point: exponent 000 is 0 regardless of mantissa; otherwise magnitude = (16+m) << e in 2^-8 units, negated when the sign bit is set.
REQ-016 SHALL add the decoded value to the accumulator, saturating at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)-1); saturation sets the sticky overflow bit.
REQ-017 SHALL OR each accepted iOverflow into the sticky overflow bit.
REQ-018 SHALL include an accepted beat with iLast=1 in the sum and then move ACC->NORM.
REQ-019 SHALL take one cycle in NORM to convert the accumulator magnitude, where p is the bit index of its leading one:
- p>11: saturate to 0x7F or 0xFF and set overflow.
- 5<=p<=11: e=p-4, m=|acc|[p-1:p-4], truncated toward zero.
- p<5 or accumulator zero: output 0x00.
REQ-020 SHALL always produce 0x00 for a zero result (never 0x80).
REQ-021 SHALL, in OUT, assert oValid for exactly one cycle with oNum and overflow stable, then clear the accumulator and sticky bit and return to ACC.
REQ-022 SHALL give fixed latency: when the iLast beat is accepted at cycle t, oValid is high at t+2 and oReady is high again at t+3.
REQ-023 SHALL hold oNum and overflow at their last result values outside OUT; only oValid qualifies them.
REQ-024 SHALL size the decode and add datapath to ACC_W; ACC_W values below 13 are unsupported.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set state ACC, accumulator 0, sticky overflow 0, oValid 0, oNum 0x00, overflow 0.
REQ-026 SHALL, on reset in mid-sum or in NORM/OUT, discard any partial sum with no oValid pulse; the first accepted beat after reset starts a new sum.
REQ-027 SHALL give rst priority over a beat accepted in the same cycle, which is discarded.

Configuration
REQ-028 SHALL provide macro FLOAT8_ACCUM_RELU_EN.
REQ-029 SHALL, when FLOAT8_ACCUM_RELU_EN is defined, force a negative result in NORM to oNum 0x00 with overflow reporting only sticky sources, i.e. negative saturation is not flagged.
REQ-030 SHALL, when FLOAT8_ACCUM_RELU_EN is undefined, output signed results per REQ-019, with no ReLU logic present.

Verification
REQ-031 SHALL verify: 0x40, then 0x40 with iLast -> oNum 0x50, overflow 0, oValid 2 cycles after the last beat.
REQ-032 SHALL verify: 0x40, then 0xC0 with iLast -> oNum 0x00, overflow 0.
REQ-033 SHALL verify: 0x7F, then 0x7F with iLast -> oNum 0x7F, overflow 1; the next sum 0x40 with iLast -> 0x40, overflow 0.
REQ-034 SHALL verify: a single 0xA0 with iLast -> 0xA0 without the macro, 0x00 with FLOAT8_ACCUM_RELU_EN.
REQ-035 SHALL verify: 0x40 with iOverflow=1, then 0x00 with iLast -> oNum 0x40, overflow 1; iValid held high through NORM/OUT is not accepted.
REQ-036 SHALL verify: 0x40, rst pulse, then 0x20 with iLast -> oNum 0x20, no oValid for the aborted sum.
